pip_bht: RTL

Branch history table feeding the fetch-stage branch predictor. The table is direct-mapped, holds 2-bit saturating counters, and is indexed by the fetch PC. It supplies `pip_cont`, the confidence value the predictor compares against 2'b10 to choose taken. It is trained by branch outcomes resolved in execute. It also provides a sequential flush sweep and branch/mispredict performance counters.

---
 rtl/pip_bht.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pip_bht.sv
// ============================================================================
//  Module   : pip_bht
//  Purpose  : Direct-mapped 2-bit branch history table with write-through
//             bypass, sequential flush sweep and branch/mispredict counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pip_bht #(
    parameter int         INDEX_W  = 6,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] fetch_pc,
    output logic [1:0]  pip_cont,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic [1:0]  upd_pred,
    input  logic        flush_bht,
    output logic        busy,
    output logic [31:0] br_total,
    output logic [31:0] br_miss
);

    localparam int ENTRIES = 1 << INDEX_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               r_state;
    logic [INDEX_W-1:0]   r_clr_idx;
    logic                 r_busy;
    logic [1:0]           r_table [ENTRIES];
    logic [31:0]          r_br_total;
    logic [31:0]          r_br_miss;

    logic [INDEX_W-1:0]   w_fetch_idx;
    logic [INDEX_W-1:0]   w_upd_idx;
    logic [1:0]           w_upd_cur;
    logic [1:0]           w_upd_next;
    logic                 w_upd_en;
    logic                 w_miss;
    logic                 w_unused;

    assign w_fetch_idx = fetch_pc[INDEX_W+1:2];
    assign w_upd_idx   = upd_pc[INDEX_W+1:2];
    assign w_upd_cur   = r_table[w_upd_idx];
    assign w_upd_en    = upd_valid && (r_state == IDLE);
    assign w_miss      = upd_pred[1] != upd_taken;

    // Upper PC bits alias by design; the low prediction bit is not needed.
    assign w_unused = ^{fetch_pc[63:INDEX_W+2], fetch_pc[1:0],
                        upd_pc[63:INDEX_W+2], upd_pc[1:0], upd_pred[0]};

    always_comb begin
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != 2'b11) w_upd_next = w_upd_cur + 2'd1;
        end else begin
            if (w_upd_cur != 2'b00) w_upd_next = w_upd_cur - 2'd1;
        end
    end

    // Same-cycle bypass lets fetch see a training result without a bubble.
    always_comb begin
        pip_cont = r_table[w_fetch_idx];
        if (r_state == CLEAR) begin
            pip_cont = INIT_CNT;
        end else if (w_upd_en && (w_fetch_idx == w_upd_idx)) begin
            pip_cont = w_upd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= INIT_CNT;
            end
        end else if (r_state == CLEAR) begin
            r_table[r_clr_idx] <= INIT_CNT;
        end else if (upd_valid) begin
            r_table[w_upd_idx] <= w_upd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_bht) begin
                        r_state   <= CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (flush_bht) begin
                        r_clr_idx <= '0;
                    end else if (r_clr_idx == {INDEX_W{1'b1}}) begin
                        r_state   <= IDLE;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clr_idx <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_total <= '0;
            r_br_miss  <= '0;
        end else if (upd_valid) begin
            if (r_br_total != 32'hFFFF_FFFF) r_br_total <= r_br_total + 32'd1;
            if (w_miss && (r_br_miss != 32'hFFFF_FFFF)) r_br_miss <= r_br_miss + 32'd1;
        end
    end

    assign busy     = r_busy;
    assign br_total = r_br_total;
    assign br_miss  = r_br_miss;

endmodule

`default_nettype wire
